// File: rtl/max7219_chain_ctrl.sv
// Serial driver for a daisy-chain of MAX7219 devices: shifts one 16-bit word per
// device MSB-first on din/clk, then pulses load to latch the whole chain.
module max7219_chain_ctrl #(
   parameter int G_MATRIX_NB = 8,
   parameter int G_CLK_DIV   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic [16*G_MATRIX_NB-1:0] i_data,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_max7219_clk,
   output logic                      o_max7219_din,
   output logic                      o_max7219_load
);

   localparam int NBITS = 16 * G_MATRIX_NB;
   localparam int BIT_W = $clog2(NBITS);
   localparam int DIV_W = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(G_CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

   typedef enum logic [2:0] {IDLE, CLK_LOW, CLK_HIGH, TAIL_LOW, LOAD_HIGH} state_t;

   state_t             state, state_nx;
   logic [DIV_W-1:0]   div_cnt, div_nx;
   logic [BIT_W-1:0]   bit_cnt, bit_nx;
   logic [NBITS-1:0]   sreg, sreg_nx;
   logic               busy_nx, done_nx, mclk_nx, din_nx, load_nx;
   logic               phase_end;

   assign phase_end = (div_cnt == DIV_LAST);

   always_comb begin
      state_nx = state;
      div_nx   = div_cnt;
      bit_nx   = bit_cnt;
      sreg_nx  = sreg;
      case (state)
         // the o_done cycle is still the tail of the previous frame, so a start there is dropped
         IDLE: begin
            if (i_start && !o_done) begin
               state_nx = CLK_LOW;
               sreg_nx  = i_data;
               bit_nx   = BIT_LAST;
               div_nx   = '0;
            end
         end
         CLK_LOW: begin
            if (phase_end) begin
               state_nx = CLK_HIGH;
               div_nx   = '0;
            end else begin
               div_nx = div_cnt + 1'b1;
            end
         end
         CLK_HIGH: begin
            if (phase_end) begin
               div_nx = '0;
               if (bit_cnt == '0) begin
                  state_nx = TAIL_LOW;
               end else begin
                  state_nx = CLK_LOW;
                  bit_nx   = bit_cnt - 1'b1;
                  sreg_nx  = {sreg[NBITS-2:0], 1'b0};
               end
            end else begin
               div_nx = div_cnt + 1'b1;
            end
         end
         TAIL_LOW: begin
            if (phase_end) begin
               state_nx = LOAD_HIGH;
               div_nx   = '0;
            end else begin
               div_nx = div_cnt + 1'b1;
            end
         end
         LOAD_HIGH: begin
            if (phase_end) begin
               state_nx = IDLE;
               div_nx   = '0;
            end else begin
               div_nx = div_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      // outputs are decoded from the next state so the registered pins line up with it
      busy_nx = (state_nx != IDLE);
      done_nx = (state == LOAD_HIGH) && (state_nx == IDLE);
      mclk_nx = (state_nx == CLK_HIGH);
      din_nx  = ((state_nx == CLK_LOW) || (state_nx == CLK_HIGH)) ? sreg_nx[NBITS-1] : 1'b0;
      load_nx = (state_nx == LOAD_HIGH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         div_cnt        <= '0;
         bit_cnt        <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_max7219_clk  <= 1'b0;
         o_max7219_din  <= 1'b0;
         o_max7219_load <= 1'b0;
      end else begin
         state          <= state_nx;
         div_cnt        <= div_nx;
         bit_cnt        <= bit_nx;
         o_busy         <= busy_nx;
         o_done         <= done_nx;
         o_max7219_clk  <= mclk_nx;
         o_max7219_din  <= din_nx;
         o_max7219_load <= load_nx;
      end
   end

   always_ff @(posedge clk) begin
      sreg <= sreg_nx;
   end

endmodule

// File: tb/tb_max7219_chain_ctrl.sv
// Bench for max7219_chain_ctrl: a default 8-device instance and a 2-device,
// divide-by-1 instance, each observed by a small chain monitor.
module tb_max7219_chain_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         a_rst, a_start, a_busy, a_done, a_mclk, a_din, a_load;
   logic [127:0] a_data;
   logic         b_rst, b_start, b_busy, b_done, b_mclk, b_din, b_load;
   logic [31:0]  b_data;

   max7219_chain_ctrl dut_a (
      .clk(clk), .rst(a_rst), .i_start(a_start), .i_data(a_data),
      .o_busy(a_busy), .o_done(a_done), .o_max7219_clk(a_mclk),
      .o_max7219_din(a_din), .o_max7219_load(a_load)
   );

   max7219_chain_ctrl #(.G_MATRIX_NB(2), .G_CLK_DIV(1)) dut_b (
      .clk(clk), .rst(b_rst), .i_start(b_start), .i_data(b_data),
      .o_busy(b_busy), .o_done(b_done), .o_max7219_clk(b_mclk),
      .o_max7219_din(b_din), .o_max7219_load(b_load)
   );

   // Chain emulator: din is shifted in on every rising serial clock edge.
   logic         a_mclk_q = 1'b0, a_load_q = 1'b0, b_mclk_q = 1'b0, b_load_q = 1'b0;
   logic [127:0] a_cap = '0;
   logic [31:0]  b_cap = '0;
   int           a_edges = 0, a_loads = 0, a_ld_cyc = 0;
   int           b_edges = 0, b_loads = 0, b_ld_cyc = 0;

   always @(negedge clk) begin
      if (a_mclk && !a_mclk_q) begin a_cap = {a_cap[126:0], a_din}; a_edges++; end
      if (a_load && !a_load_q) a_loads++;
      if (a_load) a_ld_cyc++;
      a_mclk_q = a_mclk; a_load_q = a_load;
      if (b_mclk && !b_mclk_q) begin b_cap = {b_cap[30:0], b_din}; b_edges++; end
      if (b_load && !b_load_q) b_loads++;
      if (b_load) b_ld_cyc++;
      b_mclk_q = b_mclk; b_load_q = b_load;
   end

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Returns cycles from the first CLK_LOW cycle to o_done, minus one (-1 on timeout).
   task automatic frame_b(input logic [31:0] d, output int dur);
      int cyc;
      @(negedge clk); b_data = d; b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      chk("b_first_cycle", {b_busy, b_mclk, b_din}, {1'b1, 1'b0, d[31]});
      cyc = 1; dur = -1;
      while (cyc < 300) begin
         if (b_done) begin dur = cyc - 1; break; end
         @(negedge clk); cyc++;
      end
   endtask

   task automatic run_a(input logic [127:0] d, input bit poke, input bit scramble,
                        input int rst_bit, output int dur);
      int cyc;
      @(negedge clk); a_data = d; a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      cyc = 1; dur = -1;
      while (cyc < 1100) begin
         if (a_done) begin
            dur = cyc - 1;
            if (poke) begin
               a_start = 1'b1;
               @(negedge clk); a_start = 1'b0;
               chk("a_done_one_cycle", a_done, 1'b0);
               chk("a_busy_after_done", a_busy, 1'b0);
            end
            break;
         end
         if (rst_bit >= 0 && cyc == 1 + 8 * rst_bit) begin
            a_rst = 1'b1;
            @(negedge clk); a_rst = 1'b0;
            chk("a_midframe_reset", {a_busy, a_done, a_mclk, a_din, a_load}, '0);
            break;
         end
         a_start = poke && (cyc == 1 + 8 * 5 || cyc == 1 + 8 * 100);
         if (scramble) a_data = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk); cyc++;
      end
      a_start = 1'b0;
   endtask

   typedef struct {
      logic [31:0] data;
      logic [31:0] exp_bits;
      int          exp_dur;
   } vec_t;

   vec_t vecs[4];

   initial begin
      int dur, e0, l0, c0;
      logic [127:0] d;

      vecs[0] = '{32'hA5C3_0F0F, 32'hA5C3_0F0F, 66};
      vecs[1] = '{32'h0000_0000, 32'h0000_0000, 66};
      vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 66};
      vecs[3] = '{32'h8001_7FFE, 32'h8001_7FFE, 66};

      a_rst = 1'b1; b_rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
      a_data = '0; b_data = '0;
      wait_cycles(3);
      chk("a_reset_outputs", {a_busy, a_done, a_mclk, a_din, a_load}, '0);
      chk("b_reset_outputs", {b_busy, b_done, b_mclk, b_din, b_load}, '0);
      a_rst = 1'b0; b_rst = 1'b0;
      wait_cycles(2);

      // Small chain, frames issued back-to-back on the first IDLE cycle after o_done.
      for (int i = 0; i < 4; i++) begin
         e0 = b_edges; l0 = b_loads; c0 = b_ld_cyc;
         frame_b(vecs[i].data, dur);
         chk("b_shifted_bits", b_cap, vecs[i].exp_bits);
         chk("b_clk_edges", b_edges - e0, 32);
         chk("b_load_pulses", b_loads - l0, 1);
         chk("b_load_width", b_ld_cyc - c0, 1);
         chk("b_done_latency", dur, vecs[i].exp_dur);
      end
      wait_cycles(3);
      chk("b_idle_busy", b_busy, 1'b0);

      // Default chain: word k = 0x0100|k, so device k row0 holds k.
      for (int k = 0; k < 8; k++) d[16*k +: 16] = 16'h0100 | 16'(k);
      e0 = a_edges; l0 = a_loads; c0 = a_ld_cyc;
      run_a(d, 1'b0, 1'b0, -1, dur);
      chk("a_done_latency", dur, 1032);
      chk("a_clk_edges", a_edges - e0, 128);
      chk("a_load_pulses", a_loads - l0, 1);
      chk("a_load_width", a_ld_cyc - c0, 4);
      for (int k = 0; k < 8; k++) begin
         chk("a_row0_addr", a_cap[16*k+8 +: 8], 8'h01);
         chk("a_row0_data", a_cap[16*k +: 8], 8'(k));
      end

      // Data scrambled during the frame must not leak into the shifted bits.
      d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      run_a(d, 1'b0, 1'b1, -1, dur);
      chk("a_captured_data", a_cap, d);
      chk("a_scramble_latency", dur, 1032);

      // i_start poked at bit 5, bit 100 and in the o_done cycle is ignored.
      d = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;
      e0 = a_edges; l0 = a_loads;
      run_a(d, 1'b1, 1'b0, -1, dur);
      chk("a_poke_latency", dur, 1032);
      wait_cycles(20);
      chk("a_poke_busy", a_busy, 1'b0);
      chk("a_poke_loads", a_loads - l0, 1);
      chk("a_poke_edges", a_edges - e0, 128);
      chk("a_poke_data", a_cap, d);

      // Reset at bit 40 aborts without load or done, then a fresh frame works.
      l0 = a_loads;
      run_a(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 40, dur);
      wait_cycles(20);
      chk("a_abort_no_load", a_loads - l0, 0);
      chk("a_abort_no_done", dur, -1);
      chk("a_abort_idle", a_busy, 1'b0);
      d = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_00FF_FF00;
      e0 = a_edges; l0 = a_loads;
      run_a(d, 1'b0, 1'b0, -1, dur);
      chk("a_fresh_data", a_cap, d);
      chk("a_fresh_latency", dur, 1032);
      chk("a_fresh_edges", a_edges - e0, 128);
      chk("a_fresh_loads", a_loads - l0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
